acc_run_sequencer: RTL

//  Wishbone-clock-domain sequencer for one accelerator job: k-d tree load, then search + best-array

---
 rtl/acc_run_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/acc_run_sequencer.sv
// Job sequencer for the accelerator: optional tree load, then search/send rounds.
// Issues one-cycle go pulses, waits for done pulses, and guards each wait with timeout/abort.
module acc_run_sequencer #(
    parameter int ITER_W     = 8,
    parameter int TMO_W      = 20,
    parameter int TMO_CYCLES = 1000000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_phases,
    input  logic [ITER_W-1:0] cmd_iters,
    input  logic              abort,
    output logic              load_go,
    output logic              fsm_go,
    output logic              send_go,
    input  logic              load_done,
    input  logic              fsm_done,
    input  logic              send_done,
    output logic              busy,
    output logic              job_done,
    output logic [1:0]        err_code,
    output logic [ITER_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_GO,
        LOAD_WAIT,
        RUN_GO,
        RUN_WAIT,
        SEND_GO,
        SEND_WAIT,
        FINISH
    } state_t;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_ABORT = 2'b10;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [2:0]        phases;
    logic [2:0]        phases_next;
    logic [ITER_W-1:0] iters;
    logic [ITER_W-1:0] iters_next;
    logic [ITER_W-1:0] iter_next;
    logic [1:0]        err_next;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [TMO_W-1:0]  tmo_next;

    logic [ITER_W:0]   iter_inc;
    logic [ITER_W-1:0] iter_sat;
    logic              more_iters;
    logic              in_wait;
    logic              wait_done;

    assign iter_inc   = {1'b0, iter_cnt} + {{ITER_W{1'b0}}, 1'b1};
    assign iter_sat   = (&iter_cnt) ? iter_cnt : iter_inc[ITER_W-1:0];
    assign more_iters = iter_inc < {1'b0, iters};

    assign in_wait   = (state == LOAD_WAIT) || (state == RUN_WAIT)
                    || (state == SEND_WAIT);
    assign wait_done = ((state == LOAD_WAIT) && load_done)
                    || ((state == RUN_WAIT) && fsm_done)
                    || ((state == SEND_WAIT) && send_done);

    always_comb begin
        state_next  = state;
        phases_next = phases;
        iters_next  = iters;
        iter_next   = iter_cnt;
        err_next    = err_code;
        tmo_next    = tmo_cnt;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    phases_next = cmd_phases;
                    iters_next  = (cmd_iters == '0) ? ITER_W'(1) : cmd_iters;
                    iter_next   = '0;
                    err_next    = ERR_OK;
                    if (cmd_phases[0])      state_next = LOAD_GO;
                    else if (cmd_phases[1]) state_next = RUN_GO;
                    else if (cmd_phases[2]) state_next = SEND_GO;
                    else                    state_next = FINISH;
                end
            end
            LOAD_GO: begin
                tmo_next   = '0;
                state_next = LOAD_WAIT;
            end
            RUN_GO: begin
                tmo_next   = '0;
                state_next = RUN_WAIT;
            end
            SEND_GO: begin
                tmo_next   = '0;
                state_next = SEND_WAIT;
            end
            LOAD_WAIT: begin
                if (load_done) begin
                    if (phases[1])      state_next = RUN_GO;
                    else if (phases[2]) state_next = SEND_GO;
                    else                state_next = FINISH;
                end
            end
            RUN_WAIT: begin
                if (fsm_done) begin
                    if (phases[2]) begin
                        state_next = SEND_GO;
                    end else begin
                        iter_next  = iter_sat;
                        state_next = more_iters ? RUN_GO : FINISH;
                    end
                end
            end
            SEND_WAIT: begin
                if (send_done) begin
                    iter_next = iter_sat;
                    if (!more_iters)    state_next = FINISH;
                    else if (phases[1]) state_next = RUN_GO;
                    else                state_next = SEND_GO;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A done landing on the last timeout cycle still wins.
        if (in_wait) begin
            tmo_next = tmo_cnt + TMO_W'(1);
            if (!wait_done && (tmo_cnt == TMO_LAST)) begin
                err_next   = ERR_TMO;
                state_next = FINISH;
            end
        end

        // Abort discards any done seen in the same cycle.
        if (abort && (state != IDLE) && (state != FINISH)) begin
            iter_next  = iter_cnt;
            err_next   = ERR_ABORT;
            state_next = FINISH;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            phases   <= '0;
            iters    <= '0;
            iter_cnt <= '0;
            err_code <= ERR_OK;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_next;
            phases   <= phases_next;
            iters    <= iters_next;
            iter_cnt <= iter_next;
            err_code <= err_next;
            tmo_cnt  <= tmo_next;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign load_go   = (state == LOAD_GO);
    assign fsm_go    = (state == RUN_GO);
    assign send_go   = (state == SEND_GO);
    assign job_done  = (state == FINISH);

endmodule
